// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump reader: FSM states and the
// default sizes used by both the reader and the Registers instantiation.
package reg_dump_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        DONE,
        CSUM
    } dump_state_t;

endpackage

// File: rtl/reg_dump_stream_out.sv
// Registered valid/ready output beat: captures a beat on i_load and holds it
// stable until the downstream handshake, so it can front any debug stream.
module reg_dump_stream_out
    import reg_dump_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_index,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_index,
    output logic              o_last,
    output logic              o_handshake
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_index;
    logic              r_last;
    logic              w_handshake;

    assign w_handshake = r_valid & i_ready;

    // Payload is only rewritten on a load; after the handshake it keeps the
    // old beat while valid is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_index <= i_index;
            r_last  <= i_last;
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_index     = r_index;
    assign o_last      = r_last;
    assign o_handshake = w_handshake;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file through one read port and streams every register
// out; define REG_DUMP_CHECKSUM_EN to append a modular-sum checksum beat.
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              stall_req_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] index_o,
    output logic              last_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              done_o
);

    dump_state_t       r_state;
    dump_state_t       w_nextState;
    logic [ADDR_W-1:0] r_ptr;
    logic              w_atLastReg;
    logic              w_handshake;
    logic              w_load;
    logic [DATA_W-1:0] w_loadData;
    logic [ADDR_W-1:0] w_loadIndex;
    logic              w_loadLast;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_acc;
`endif

    assign w_atLastReg = (r_ptr == ADDR_W'(NUM_REGS - 1));
    assign rf_addr_o   = r_ptr;
    assign stall_req_o = busy_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The pointer stops on the last register; the dump ends from there
    // instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (r_state == IDLE && start_i) begin
            r_ptr <= '0;
        end else if (r_state == SEND && w_handshake && !last_o && !w_atLastReg) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc <= '0;
        end else if (r_state == IDLE && start_i) begin
            r_acc <= '0;
        end else if (r_state == FETCH) begin
            r_acc <= r_acc + rf_data_i;
        end
    end
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (start_i) w_nextState = FETCH;
            FETCH: w_nextState = SEND;
            SEND: begin
                if (w_handshake) begin
                    if (last_o) begin
                        w_nextState = DONE;
`ifdef REG_DUMP_CHECKSUM_EN
                    end else if (w_atLastReg) begin
                        w_nextState = CSUM;
`endif
                    end else begin
                        w_nextState = FETCH;
                    end
                end
            end
            DONE:  w_nextState = IDLE;
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM:  w_nextState = SEND;
`endif
            default: w_nextState = IDLE;
        endcase
    end

    // With the checksum enabled the last register is not the final beat;
    // the CSUM beat carries last instead.
    always_comb begin
        busy_o      = (r_state != IDLE);
        done_o      = (r_state == DONE);
        w_load      = 1'b0;
        w_loadData  = rf_data_i;
        w_loadIndex = r_ptr;
`ifdef REG_DUMP_CHECKSUM_EN
        w_loadLast  = 1'b0;
`else
        w_loadLast  = w_atLastReg;
`endif
        case (r_state)
            FETCH: w_load = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                w_load      = 1'b1;
                w_loadData  = r_acc;
                w_loadIndex = '0;
                w_loadLast  = 1'b1;
            end
`endif
            default: w_load = 1'b0;
        endcase
    end

    reg_dump_stream_out #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_streamOut (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_load      (w_load),
        .i_data      (w_loadData),
        .i_index     (w_loadIndex),
        .i_last      (w_loadLast),
        .i_ready     (ready_i),
        .o_valid     (valid_o),
        .o_data      (data_o),
        .o_index     (index_o),
        .o_last      (last_o),
        .o_handshake (w_handshake)
    );

endmodule
